operand_issue_arbiter: RTL and testbench

- Shares one fixed-latency 16-bit floating-point operand datapath (MAC/ALU) among NUM_REQ requesters.
- Each requester presents an operand pair (A, B). The block grants requesters round-robin, registers the pair onto the datapath with a one-cycle start strobe, and tracks a requester tag through the pipeline.
- Results are buffered in a small result FIFO and returned tagged with requester ID.
- A credit counter prevents result FIFO overflow when the consumer stalls.

---
 rtl/operand_issue_arbiter.sv | 154 +++++++++++++++
 tb/tb_operand_issue_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue_arbiter.sv
// Purpose: round-robin issue of NUM_REQ operand pairs onto one shared fixed-latency datapath, with tagged in-order results.
// Latency: grant in cycle N, dp_start in N+1, result captured in N+1+PIPE_LAT, resp_valid visible in N+2+PIPE_LAT.
// Backpressure: a credit counter admits at most RES_DEPTH operations from grant to pop, so the result FIFO never overflows.
//
// Ports:
//   clk, rst (async, active low)
//   req_valid/req_ready      per-requester handshake; req_a/req_b packed DATA_W slices per requester
//   dp_a/dp_b/dp_start       registered operands and one-cycle start strobe to the datapath
//   dp_result                datapath output, valid PIPE_LAT cycles after dp_start
//   resp_valid/resp_ready    result FIFO head handshake; resp_id/resp_data describe the head
//   idle                     no operation outstanding
module operand_issue_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int PIPE_LAT  = 3,
  parameter int RES_DEPTH = 4,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(RES_DEPTH + 1),
  localparam int PTR_W    = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         dp_a,
  output logic [DATA_W-1:0]         dp_b,
  output logic                      dp_start,
  input  logic [DATA_W-1:0]         dp_result,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      idle
);

  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  outstanding;
  logic              grant;
  logic [ID_W-1:0]   grant_id;
  int                idx;

  // Tag pipeline: stage 0 is aligned with dp_start, stage PIPE_LAT with dp_result.
  logic [PIPE_LAT:0] tag_v;
  logic [ID_W-1:0]   tag_id [PIPE_LAT+1];

  logic [ID_W-1:0]   mem_id  [RES_DEPTH];
  logic [DATA_W-1:0] mem_dat [RES_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push, pop;
  logic [ID_W-1:0]   head_id;
  logic [DATA_W-1:0] head_dat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration: the credit check uses the registered count only, so a pop
  // in this cycle frees a slot for the next cycle, not this one.
  always_comb begin
    req_ready = '0;
    grant     = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (outstanding < CNT_W'(RES_DEPTH)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant && req_valid[idx]) begin
          grant    = 1'b1;
          grant_id = ID_W'(idx);
        end
      end
      if (grant) req_ready[grant_id] = 1'b1;
    end
  end

  assign push = tag_v[PIPE_LAT];
  assign pop  = resp_valid & resp_ready;
  assign idle = (outstanding == '0);

  // Next FIFO head. The credit rule means a push never meets a full FIFO,
  // so write pointer == next read pointer only when the pushed entry becomes
  // the head (empty FIFO, or last entry popped in the same cycle).
  always_comb begin
    rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
    count_nxt  = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_id  = tag_id[PIPE_LAT];
      head_dat = dp_result;
    end else begin
      head_id  = mem_id[rd_ptr_nxt];
      head_dat = mem_dat[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr      <= '0;
      outstanding <= '0;
      dp_start    <= 1'b0;
      dp_a        <= '0;
      dp_b        <= '0;
      tag_v       <= '0;
      for (int k = 0; k <= PIPE_LAT; k++) tag_id[k] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_data   <= '0;
    end else begin
      dp_start <= grant;
      if (grant) begin
        dp_a   <= req_a[int'(grant_id)*DATA_W +: DATA_W];
        dp_b   <= req_b[int'(grant_id)*DATA_W +: DATA_W];
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end

      if (grant && !pop)      outstanding <= outstanding + 1'b1;
      else if (!grant && pop) outstanding <= outstanding - 1'b1;

      tag_v[0]  <= grant;
      tag_id[0] <= grant_id;
      for (int k = 1; k <= PIPE_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      resp_valid <= (count_nxt != '0);
      // Head registers hold their last value once the FIFO drains.
      if (count_nxt != '0) begin
        resp_id   <= head_id;
        resp_data <= head_dat;
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]  <= tag_id[PIPE_LAT];
      mem_dat[wr_ptr] <= dp_result;
    end
  end

endmodule

// File: tb/tb_operand_issue_arbiter.sv
module tb_operand_issue_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 16;
  localparam int PIPE_LAT  = 3;
  localparam int RES_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [15:0] dp_a, dp_b, dp_result, resp_data;
  logic        dp_start, resp_valid, resp_ready, idle;
  logic [1:0]  resp_id;

  int nchk = 0;
  int npass = 0;

  logic [15:0] m_d [PIPE_LAT];
  logic [17:0] exp_resp [$];
  logic [31:0] exp_dp [$];
  int          grants [$];

  int          g;
  logic [31:0] e_dp;
  logic [17:0] e_resp;
  int          gbase;
  int          bad;

  always #5 clk = ~clk;

  operand_issue_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PIPE_LAT(PIPE_LAT), .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .dp_a(dp_a), .dp_b(dp_b), .dp_start(dp_start), .dp_result(dp_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .idle(idle)
  );

  // Datapath stand-in: fixed latency, not reset, keeps running through rst.
  function automatic logic [15:0] dp_func(input logic [15:0] a, input logic [15:0] b);
    return a ^ b ^ 16'h3C00;
  endfunction

  always @(posedge clk) begin
    m_d[0] <= dp_start ? dp_func(dp_a, dp_b) : 16'hDEAD;
    for (int k = 1; k < PIPE_LAT; k++) m_d[k] <= m_d[k-1];
  end
  assign dp_result = m_d[PIPE_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rand_ops();
    req_a = {$urandom(), $urandom()};
    req_b = {$urandom(), $urandom()};
  endtask

  // Scoreboard monitor: grants push expected operands/results, dp_start and
  // response pops compare against them in order.
  always @(negedge clk) begin
    if (!rst) begin
      exp_resp.delete();
      exp_dp.delete();
    end else begin
      if (dp_start) begin
        if (exp_dp.size() == 0) check("dp_unexpected", 32'(dp_start), 0);
        else begin
          e_dp = exp_dp.pop_front();
          check("dp_a", 32'(dp_a), 32'(e_dp[31:16]));
          check("dp_b", 32'(dp_b), 32'(e_dp[15:0]));
        end
      end
      if (resp_valid && resp_ready) begin
        if (exp_resp.size() == 0) check("resp_unexpected", 32'(resp_valid), 0);
        else begin
          e_resp = exp_resp.pop_front();
          check("resp_id", 32'(resp_id), 32'(e_resp[17:16]));
          check("resp_data", 32'(resp_data), 32'(e_resp[15:0]));
        end
      end
      check("rdy_legal", 32'($onehot0(req_ready) && ((req_ready & ~req_valid) == 4'b0)), 1);
      if (|(req_valid & req_ready)) begin
        g = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_ready[i]) g = i;
        grants.push_back(g);
        exp_dp.push_back({req_a[g*16 +: 16], req_b[g*16 +: 16]});
        exp_resp.push_back({2'(g), dp_func(req_a[g*16 +: 16], req_b[g*16 +: 16])});
      end
    end
  end

  task automatic drain(input string tag);
    int c;
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    c = 0;
    @(negedge clk);
    while (!(idle && !resp_valid) && c < 50) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(idle && !resp_valid), 1);
    check({tag, "_sb"}, 32'(exp_resp.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_dp_start", 32'(dp_start), 0);
    check("rst_dp_a", 32'(dp_a), 0);
    check("rst_dp_b", 32'(dp_b), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_id", 32'(resp_id), 0);
    check("rst_resp_data", 32'(resp_data), 0);
    check("rst_idle", 32'(idle), 1);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_no_grant", 32'(req_ready), 0);
      check("idle_no_start", 32'(dp_start), 0);
    end

    // Single request from requester 1.
    @(posedge clk); #1;
    req_valid = 4'b0010; req_a[31:16] = 16'h3C00; req_b[31:16] = 16'h4000;
    @(negedge clk);
    check("single_rdy", 32'(req_ready), 32'h2);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    check("single_start", 32'(dp_start), 1);
    check("single_dp_a", 32'(dp_a), 32'h3C00);
    check("single_dp_b", 32'(dp_b), 32'h4000);
    check("single_busy", 32'(idle), 0);
    repeat (3) @(negedge clk);
    check("single_early", 32'(resp_valid), 0);
    @(negedge clk);
    check("single_resp_valid", 32'(resp_valid), 1);
    check("single_resp_id", 32'(resp_id), 1);
    check("single_resp_data", 32'(resp_data), 32'h4000);
    check("single_busy2", 32'(idle), 0);
    @(posedge clk); #1; resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_popped", 32'(resp_valid), 0);
    check("single_idle", 32'(idle), 1);

    // Round robin: pointer sits at 2 after granting requester 1.
    grants.delete();
    @(posedge clk); #1; req_valid = 4'b1111; rand_ops();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (grants.size() >= 6) break;
      @(posedge clk); #1; rand_ops();
    end
    @(posedge clk); #1; req_valid = '0;
    check("rr_count", 32'(grants.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < grants.size()) check("rr_order", 32'(grants[i]), 32'((2 + i) % 4));
    drain("rr_drain");

    // Credit stall: exactly RES_DEPTH grants with the consumer stopped.
    @(posedge clk); #1; resp_ready = 1'b0; req_valid = 4'b1111; rand_ops();
    gbase = grants.size();
    repeat (12) begin
      @(negedge clk);
      @(posedge clk); #1; rand_ops();
    end
    @(negedge clk);
    check("stall_grants", 32'(grants.size() - gbase), 4);
    check("stall_rdy", 32'(req_ready), 0);
    check("stall_resp", 32'(resp_valid), 1);
    @(posedge clk); #1; resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; resp_ready = 1'b0;
    @(negedge clk);
    check("credit_one", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("credit_rdy0", 32'(req_ready), 0);
    check("credit_grants", 32'(grants.size() - gbase), 5);
    drain("stall_drain");

    // Pointer fairness: after 2, requester 3 beats requester 0.
    @(posedge clk); #1; req_valid = 4'b0100;
    @(negedge clk);
    check("fair_g2", 32'(req_ready), 32'h4);
    @(posedge clk); #1; req_valid = 4'b1001;
    @(negedge clk);
    check("fair_g3", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    @(negedge clk);
    check("fair_g0", 32'(req_ready), 32'h1);
    drain("fair_drain");

    // Reset with two operations in flight.
    @(posedge clk); #1; resp_ready = 1'b0; req_valid = 4'b0010;
    @(negedge clk);
    check("mid_g1", 32'(req_ready), 32'h2);
    @(posedge clk); #1; req_valid = 4'b0100;
    @(negedge clk);
    check("mid_g2", 32'(req_ready), 32'h4);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    check("mid_inflight", 32'(idle), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || idle !== 1'b1) bad++;
    end
    check("mid_quiet", 32'(bad), 0);
    @(posedge clk); #1; req_valid = 4'b1111; rand_ops();
    @(negedge clk);
    check("post_rst_g0", 32'(req_ready), 32'h1);
    drain("final_drain");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
